// File: rtl/jtag_chain_arbiter_pkg.sv
// jtag_chain_arbiter_pkg: owner codes, arbiter FSM states and the shift-length limit
package jtag_chain_arbiter_pkg;
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_EXT  = 2'd1;
  localparam logic [1:0] OWN_INT  = 2'd2;
  localparam logic [5:0] MAX_LEN  = 6'd32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
`ifdef JTAG_ARB_TLR_EN
    S_INT_TLR,
`endif
    S_INT_SHIFT,
    S_INT_DONE
  } state_t;
  function automatic logic [5:0] sat_len(input logic [5:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction
endpackage

// File: rtl/jtag_chain_arbiter_tck_gen.sv
// jtag_tck_gen: divided internal TCK (low half then high half) with low-start, rise and last-cycle strobes
module jtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_low_start,
  output logic o_rise,
  output logic o_last
);
  localparam int CW = $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] C_HI  = CW'(TCK_DIV);
  localparam logic [CW-1:0] C_END = CW'(2 * TCK_DIV - 1);
  logic [CW-1:0] r_cnt;
  logic          r_tck;
  // walk one TCK period per bit; TCK rises at count TCK_DIV and falls when the period wraps
  always_ff @(posedge clk)
    if (!rst_n || !i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == C_END) ? '0 : r_cnt + 1'b1;
      r_tck <= (r_cnt == C_HI - 1'b1) ? 1'b1 : (r_cnt == C_END) ? 1'b0 : r_tck;
    end
  assign o_tck       = r_tck;
  assign o_low_start = i_en && r_cnt == '0;
  assign o_rise      = i_en && r_cnt == C_HI;
  assign o_last      = i_en && r_cnt == C_END;
endmodule

// File: rtl/jtag_chain_arbiter.sv
// jtag_chain_arbiter: shares the Atlas JTAG chain between an external USB-Blaster and an internal shifter (JTAG_ARB_TLR_EN adds a TLR+RTI preamble)
module jtag_chain_arbiter
  import jtag_chain_arbiter_pkg::*;
#(
  parameter int TCK_DIV      = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_tdi,
  input  logic        ext_tck,
  input  logic        ext_tms,
  output logic        ext_tdo,
  output logic        atlas_tms,
  output logic        atlas_tck,
  output logic        atlas_tdi,
  input  logic        atlas_tdo,
  input  logic        req,
  input  logic [5:0]  len,
  input  logic [31:0] tms_vec,
  input  logic [31:0] tdi_vec,
  output logic        busy,
  output logic        done,
  output logic [31:0] tdo_vec,
  output logic [1:0]  owner
);
  localparam logic [15:0] TO_LOAD = 16'(IDLE_TIMEOUT - 1);
  state_t      r_state;
  logic [1:0]  r_sync;
  logic        r_prev;
  logic [15:0] r_to;
  logic        r_pend;
  logic [5:0]  r_len;
  logic [31:0] r_tmsv;
  logic [31:0] r_tdiv;
  logic [31:0] r_cap;
  logic [31:0] r_tdo;
  logic [4:0]  r_bit;
  logic        r_tms;
  logic        r_tdi;
`ifdef JTAG_ARB_TLR_EN
  logic [2:0]  r_tlr;
`endif
  logic w_act, w_ext, w_en, w_tck, w_low, w_rise, w_last;
  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk(clk), .rst_n(rst_n), .i_en(w_en),
    .o_tck(w_tck), .o_low_start(w_low), .o_rise(w_rise), .o_last(w_last)
  );
  assign w_act = r_sync[1] ^ r_prev;
  assign w_ext = r_state == S_EXT;
`ifdef JTAG_ARB_TLR_EN
  assign w_en = r_state == S_INT_SHIFT || r_state == S_INT_TLR;
`else
  assign w_en = r_state == S_INT_SHIFT;
`endif
  assign atlas_tck = w_ext ? ext_tck : w_tck;
  assign atlas_tms = w_ext ? ext_tms : r_tms;
  assign atlas_tdi = w_ext ? ext_tdi : r_tdi;
  assign ext_tdo   = w_ext & atlas_tdo;
  assign busy      = w_en || r_state == S_INT_DONE;
  assign done      = r_state == S_INT_DONE;
  assign owner     = w_ext ? OWN_EXT : busy ? OWN_INT : OWN_IDLE;
  assign tdo_vec   = r_tdo;
  // arbiter FSM: ext_tck edge detect, ownership, internal shift sequencing and TDO capture
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_to    <= '0;
      r_pend  <= 1'b0;
      r_len   <= '0;
      r_tmsv  <= '0;
      r_tdiv  <= '0;
      r_cap   <= '0;
      r_tdo   <= '0;
      r_bit   <= '0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
`ifdef JTAG_ARB_TLR_EN
      r_tlr   <= '0;
`endif
    end else begin
      r_sync <= {r_sync[0], ext_tck};
      r_prev <= r_sync[1];
      case (r_state)
        S_IDLE:
          if (w_act) begin
            r_state <= S_EXT;
            r_to    <= TO_LOAD;
          end else if (req) begin
            r_len  <= sat_len(len);
            r_tmsv <= tms_vec;
            r_tdiv <= tdi_vec;
`ifdef JTAG_ARB_TLR_EN
            r_tlr   <= '0;
            r_state <= S_INT_TLR;
`else
            r_state <= (len == '0) ? S_INT_DONE : S_INT_SHIFT;
            if (len == '0) r_tdo <= '0;
`endif
          end
        S_EXT:
          if (w_act) r_to <= TO_LOAD;
          else if (r_to == '0) r_state <= S_IDLE;
          else r_to <= r_to - 1'b1;
`ifdef JTAG_ARB_TLR_EN
        S_INT_TLR: begin
          r_pend <= r_pend | w_act;
          if (w_low) begin
            r_tms <= r_tlr != 3'd5;
            r_tdi <= 1'b0;
          end
          if (w_last) begin
            r_tlr <= r_tlr + 3'd1;
            if (r_tlr == 3'd5) begin
              r_state <= (r_len == '0) ? S_INT_DONE : S_INT_SHIFT;
              r_tdo   <= r_cap;
              if (r_len == '0) r_tms <= 1'b1;
            end
          end
        end
`endif
        S_INT_SHIFT: begin
          r_pend <= r_pend | w_act;
          if (w_low) begin
            r_tms <= r_tmsv[r_bit];
            r_tdi <= r_tdiv[r_bit];
          end
          if (w_rise) r_cap[r_bit] <= atlas_tdo;
          if (w_last) begin
            if ({1'b0, r_bit} == r_len - 6'd1) begin
              r_state <= S_INT_DONE;
              r_tdo   <= r_cap;
              r_tms   <= 1'b1;
              r_tdi   <= 1'b0;
            end else r_bit <= r_bit + 5'd1;
          end
        end
        S_INT_DONE: begin
          r_state <= (r_pend || w_act) ? S_EXT : S_IDLE;
          r_to    <= TO_LOAD;
          r_pend  <= 1'b0;
          r_cap   <= '0;
          r_bit   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_jtag_chain_arbiter.sv
// tb_jtag_chain_arbiter: directed bench with a tdo_vec scoreboard for jtag_chain_arbiter
module tb_jtag_chain_arbiter;
  localparam int TCK_DIV      = 2;
  localparam int IDLE_TIMEOUT = 16;
`ifdef JTAG_ARB_TLR_EN
  localparam int TLR_BITS = 6;
`else
  localparam int TLR_BITS = 0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_tdi = 1'b0, ext_tck = 1'b0, ext_tms = 1'b0;
  logic        ext_tdo;
  logic        atlas_tms, atlas_tck, atlas_tdi, atlas_tdo;
  logic        req = 1'b0;
  logic [5:0]  len = '0;
  logic [31:0] tms_vec = '0, tdi_vec = '0;
  logic        busy, done;
  logic [31:0] tdo_vec;
  logic [1:0]  owner;
  logic [1:0]  lp = 2'd0;
  logic        tdo_drv = 1'b0;
  int          checks = 0, errors = 0, n_edges = 0, n_done = 0, exp_done = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  jtag_chain_arbiter #(.TCK_DIV(TCK_DIV), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ext_tdi(ext_tdi), .ext_tck(ext_tck), .ext_tms(ext_tms), .ext_tdo(ext_tdo),
    .atlas_tms(atlas_tms), .atlas_tck(atlas_tck), .atlas_tdi(atlas_tdi), .atlas_tdo(atlas_tdo),
    .req(req), .len(len), .tms_vec(tms_vec), .tdi_vec(tdi_vec),
    .busy(busy), .done(done), .tdo_vec(tdo_vec), .owner(owner)
  );

  assign atlas_tdo = (lp == 2'd1) ? atlas_tdi : (lp == 2'd2) ? atlas_tms : tdo_drv;
  always #5 clk = ~clk;
  always @(posedge atlas_tck) n_edges++;
  always @(negedge clk) if (rst_n && done) n_done++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_tck"}, 32'(atlas_tck), 32'd0);
    check({tag, "_tms"}, 32'(atlas_tms), 32'd1);
    check({tag, "_tdi"}, 32'(atlas_tdi), 32'd0);
    check({tag, "_extdo"}, 32'(ext_tdo), 32'd0);
    check({tag, "_vec"}, tdo_vec, 32'd0);
  endtask

  task automatic run_shift(input string tag, input int limit, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!done && n < limit);
    check({tag, "_done"}, 32'(done), 32'd1);
    if (done && exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check({tag, "_tdo_vec"}, tdo_vec, last_exp);
    end
    if (done) exp_done++;
  endtask

  initial begin
    int n, e0;
    logic [31:0] v;
    tick(3);
    check_idle("reset");
    rst_n = 1'b1;
    tick(4);
    check_idle("post_reset");
    // external host takes the chain
    tdo_drv = 1'b1; ext_tms = 1'b1; ext_tdi = 1'b1; ext_tck = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (owner != 2'd1 && n < 3);
    check("ext_owner", 32'(owner), 32'd1);
    check("ext_tck_copy", 32'(atlas_tck), 32'd1);
    check("ext_tdo_copy", 32'(ext_tdo), 32'd1);
    check("ext_tms_copy", 32'(atlas_tms), 32'd1);
    for (int i = 1; i < 10; i++) begin
      tick(2);
      ext_tck = ~ext_tck;
      ext_tdi = i[0];
      #1;
      check("ext_tck_follow", 32'(atlas_tck), 32'(ext_tck));
      check("ext_tdi_follow", 32'(atlas_tdi), 32'(ext_tdi));
    end
    tdo_drv = 1'b0;
    #1;
    check("ext_tdo_low", 32'(ext_tdo), 32'd0);
    // release: 2 sync flops + 1 detect cycle + IDLE_TIMEOUT idle cycles
    n = 0;
    do begin tick(1); n++; end while (owner == 2'd1 && n < 40);
    check("timeout_cycles", 32'(n), 32'(3 + IDLE_TIMEOUT));
    check_idle("after_timeout");
    // full 32-bit internal shift with TDI looped back
    e0 = n_edges; lp = 2'd1;
    len = 6'd32; tms_vec = '0; tdi_vec = 32'hA5A5A5A5; req = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    tick(1);
    req = 1'b0; tdi_vec = '0; len = '0;
    check("int_owner", 32'(owner), 32'd2);
    check("int_busy", 32'(busy), 32'd1);
    run_shift("full", 400, n);
    check("full_edges", 32'(n_edges - e0), 32'(32 + TLR_BITS));
    tick(1);
    check("done_width", 32'(done), 32'd0);
    check("tdo_hold", tdo_vec, last_exp);
    check("full_idle_owner", 32'(owner), 32'd0);
    // req coincides with the first synchronized ext_tck edge: external wins
    ext_tck = 1'b1;
    tick(2);
    req = 1'b1; len = 6'd4; tms_vec = '0; tdi_vec = 32'h5;
    exp_q.push_back(32'h5);
    tick(1);
    check("race_owner", 32'(owner), 32'd1);
    check("race_busy", 32'(busy), 32'd0);
    e0 = n_edges;
    n = 0;
    do begin tick(1); n++; end while (owner == 2'd1 && n < 40);
    check("race_ext_cycles", 32'(n), 32'(IDLE_TIMEOUT));
    check("race_no_int_tck", 32'(n_edges - e0), 32'd0);
    tick(1);
    check("race_granted", 32'(owner), 32'd2);
    req = 1'b0;
    run_shift("race", 100, n);
    check("race_edges", 32'(n_edges - e0), 32'(4 + TLR_BITS));
    ext_tck = 1'b0;
    tick(IDLE_TIMEOUT + 6);
    check("race_release", 32'(owner), 32'd0);
    // reset in the middle of bit 7 of a 20-bit shift
    e0 = n_edges;
    len = 6'd20; tdi_vec = $urandom; tms_vec = '0; req = 1'b1;
    tick(1);
    req = 1'b0;
    n = 0;
    while (n_edges - e0 < 7 + TLR_BITS && n < 300) begin tick(1); n++; end
    check("abort_reach_bit7", 32'(n_edges - e0), 32'(7 + TLR_BITS));
    tick(TCK_DIV + 1);
    rst_n = 1'b0;
    tick(1);
    check_idle("abort");
    rst_n = 1'b1;
    tick(5);
    check_idle("post_abort");
    // len 63 saturates to 32; ext activity during the shift is deferred
    e0 = n_edges; lp = 2'd2; v = $urandom;
    len = 6'd63; tms_vec = v; tdi_vec = $urandom; req = 1'b1;
    exp_q.push_back(v);
    tick(1);
    req = 1'b0;
    tick(10);
    ext_tck = 1'b1;
    tick(6);
    check("nopreempt_owner", 32'(owner), 32'd2);
    check("nopreempt_extdo", 32'(ext_tdo), 32'd0);
    run_shift("sat", 400, n);
    check("sat_edges", 32'(n_edges - e0), 32'(32 + TLR_BITS));
    tick(1);
    check("pending_to_ext", 32'(owner), 32'd1);
    tick(IDLE_TIMEOUT + 2);
    check("pending_release", 32'(owner), 32'd0);
    // len 0: no TCK edges, done right after grant, tdo_vec cleared
    e0 = n_edges;
    len = 6'd0; req = 1'b1;
    exp_q.push_back(32'h0);
    run_shift("len0", 100, n);
    req = 1'b0;
    check("len0_latency", 32'(n), 32'(1 + TLR_BITS * 2 * TCK_DIV));
    check("len0_edges", 32'(n_edges - e0), 32'(TLR_BITS));
    tick(3);
    check("done_pulses", 32'(n_done), 32'(exp_done));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
